// File: rtl/divide_pkg.sv
// Shared types and sizing for the sequential divider.
package divide_pkg;

   localparam int DIV_D_WIDTH = 32;
   localparam int DIV_CNT_W   = $clog2(DIV_D_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ZERO,
      DONE
   } div_state_t;

endpackage

// File: rtl/divide_if.sv
// Request/result bundle between the execute stage and the divider.
// signed_i exists only when DIVIDE_SIGNED_EN is defined.
interface divide_if #(parameter int D_WIDTH = 32);

   logic               start_i;
   logic [D_WIDTH-1:0] dividend_i;
   logic [D_WIDTH-1:0] divisor_i;
`ifdef DIVIDE_SIGNED_EN
   logic               signed_i;
`endif
   logic               ready_o;
   logic               done_o;
   logic [D_WIDTH-1:0] quotient_o;
   logic [D_WIDTH-1:0] remainder_o;
   logic               div_by_zero_o;

   modport master (
`ifdef DIVIDE_SIGNED_EN
      output signed_i,
`endif
      output start_i, dividend_i, divisor_i,
      input  ready_o, done_o, quotient_o, remainder_o, div_by_zero_o
   );

   modport slave (
`ifdef DIVIDE_SIGNED_EN
      input  signed_i,
`endif
      input  start_i, dividend_i, divisor_i,
      output ready_o, done_o, quotient_o, remainder_o, div_by_zero_o
   );

endinterface

// File: rtl/divide_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep the result if it
// did not go negative and shift the outcome in as the next quotient bit.
module divide_step #(parameter int D_WIDTH = 32) (
   input  logic [D_WIDTH:0]   i_rem,
   input  logic [D_WIDTH-1:0] i_q,
   input  logic [D_WIDTH-1:0] i_divisor,
   output logic [D_WIDTH:0]   o_rem,
   output logic [D_WIDTH-1:0] o_q
);

   logic [D_WIDTH:0] w_shift;
   logic [D_WIDTH:0] w_diff;
   logic             w_ge;
   logic             w_unused_rem_msb;

   // The remainder is always below the divisor after a step, so its top bit
   // is never set going in; the extra bit only matters after the shift.
   assign w_unused_rem_msb = i_rem[D_WIDTH];

   assign w_shift = {i_rem[D_WIDTH-1:0], i_q[D_WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, i_divisor};
   assign w_ge    = (w_shift >= {1'b0, i_divisor});
   assign o_rem   = w_ge ? w_diff : w_shift;
   assign o_q     = {i_q[D_WIDTH-2:0], w_ge};

endmodule

// File: rtl/divide_seq.sv
// Iterative restoring divider, one quotient bit per clock.
// Optional two's-complement mode is enabled by defining DIVIDE_SIGNED_EN.
//
// state | meaning
// IDLE  | ready for a request; results of the last operation held
// RUN   | one divide_step per cycle, count runs down to 0
// ZERO  | divisor was 0; load all-ones quotient and raw dividend
// DONE  | results valid, done_o pulses for this single cycle
module divide_seq
   import divide_pkg::*;
#(
   parameter int D_WIDTH = DIV_D_WIDTH
) (
   input logic clk_i,
   input logic rst_i,
   divide_if.slave bus
);

   localparam int CNT_W = (D_WIDTH == DIV_D_WIDTH) ? DIV_CNT_W : $clog2(D_WIDTH);

   div_state_t         r_state;
   div_state_t         w_state_nxt;
   logic [CNT_W-1:0]   r_count;
   logic [D_WIDTH:0]   r_rem;
   logic [D_WIDTH-1:0] r_q;
   logic [D_WIDTH-1:0] r_divisor;
   logic               r_neg_q;
   logic               r_neg_r;
   logic [D_WIDTH-1:0] r_quotient;
   logic [D_WIDTH-1:0] r_remainder;
   logic               r_dbz;

   logic [D_WIDTH:0]   w_rem_nxt;
   logic [D_WIDTH-1:0] w_q_nxt;
   logic               w_div_zero;
   logic [D_WIDTH-1:0] w_dvd_mag;
   logic [D_WIDTH-1:0] w_dvs_mag;
   logic               w_neg_q_in;
   logic               w_neg_r_in;
   logic [D_WIDTH-1:0] w_q_fix;
   logic [D_WIDTH-1:0] w_r_fix;
   logic               w_ready;
   logic               w_done;

   assign w_div_zero = (bus.divisor_i == '0);

`ifdef DIVIDE_SIGNED_EN
   logic w_dvd_neg;
   logic w_dvs_neg;
   assign w_dvd_neg  = bus.signed_i & bus.dividend_i[D_WIDTH-1];
   assign w_dvs_neg  = bus.signed_i & bus.divisor_i[D_WIDTH-1];
   assign w_dvd_mag  = w_dvd_neg ? -bus.dividend_i : bus.dividend_i;
   assign w_dvs_mag  = w_dvs_neg ? -bus.divisor_i : bus.divisor_i;
   assign w_neg_q_in = w_dvd_neg ^ w_dvs_neg;
   assign w_neg_r_in = w_dvd_neg;
`else
   assign w_dvd_mag  = bus.dividend_i;
   assign w_dvs_mag  = bus.divisor_i;
   assign w_neg_q_in = 1'b0;
   assign w_neg_r_in = 1'b0;
`endif

   divide_step #(.D_WIDTH(D_WIDTH)) u_step (
      .i_rem     (r_rem),
      .i_q       (r_q),
      .i_divisor (r_divisor),
      .o_rem     (w_rem_nxt),
      .o_q       (w_q_nxt)
   );

   // Sign fixup is applied on the final step's outputs so it costs no cycle;
   // negating MIN wraps back to MIN, which gives MIN/-1 = MIN for free.
   assign w_q_fix = r_neg_q ? -w_q_nxt : w_q_nxt;
   assign w_r_fix = r_neg_r ? -w_rem_nxt[D_WIDTH-1:0] : w_rem_nxt[D_WIDTH-1:0];

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (bus.start_i) w_state_nxt = w_div_zero ? ZERO : RUN;
         end
         RUN:  if (r_count == '0) w_state_nxt = DONE;
         ZERO: w_state_nxt = DONE;
         DONE: begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand capture, iteration datapath, down-counter and result registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_count     <= '0;
         r_rem       <= '0;
         r_q         <= '0;
         r_divisor   <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.start_i) begin
               // a zero divisor reports the untouched dividend, so skip the magnitude
               r_q       <= w_div_zero ? bus.dividend_i : w_dvd_mag;
               r_divisor <= w_dvs_mag;
               r_rem     <= '0;
               r_count   <= CNT_W'(D_WIDTH - 1);
               r_neg_q   <= w_neg_q_in;
               r_neg_r   <= w_neg_r_in;
            end
            RUN: begin
               r_rem <= w_rem_nxt;
               r_q   <= w_q_nxt;
               if (r_count == '0) begin
                  r_quotient  <= w_q_fix;
                  r_remainder <= w_r_fix;
                  r_dbz       <= 1'b0;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            ZERO: begin
               r_quotient  <= '1;
               r_remainder <= r_q;
               r_dbz       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.ready_o       = w_ready;
   assign bus.done_o        = w_done;
   assign bus.quotient_o    = r_quotient;
   assign bus.remainder_o   = r_remainder;
   assign bus.div_by_zero_o = r_dbz;

endmodule

// File: tb/tb_divide_seq.sv
// Directed and random checks of divide_seq against an arithmetic reference.
module tb_divide_seq;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   divide_if #(.D_WIDTH(W)) bus();

   divide_seq #(.D_WIDTH(W)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic division, with the divide-by-zero and
   // MIN/-1 results defined explicitly.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      sa = a;
      sb = b;
      dz = 1'b0;
      if (b == '0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else if (sgn) begin
         if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            q = a;
            r = '0;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input int inj_cyc, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input int rst_cyc, input string tag);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         edz;
      int           lat;
      int           cyc;
      bit           seen;
      model(a, b, sgn, eq, er, edz);
      lat = (b == '0) ? 2 : W + 1;
      @(negedge clk);
      bus.start_i    = 1'b1;
      bus.dividend_i = a;
      bus.divisor_i  = b;
`ifdef DIVIDE_SIGNED_EN
      bus.signed_i   = sgn;
`endif
      @(negedge clk);
      bus.start_i = 1'b0;
      cyc  = 1;
      seen = 1'b0;
      while (!seen && cyc <= W + 10) begin
         if (cyc == rst_cyc) begin
            rst = 1'b1;
            #1;
            chk({tag, ".rst_ready"}, W'(bus.ready_o), W'(1));
            chk({tag, ".rst_done"}, W'(bus.done_o), W'(0));
            chk({tag, ".rst_q"}, bus.quotient_o, '0);
            chk({tag, ".rst_r"}, bus.remainder_o, '0);
            chk({tag, ".rst_dz"}, W'(bus.div_by_zero_o), W'(0));
            repeat (3) begin
               @(negedge clk);
               chk({tag, ".rst_no_done"}, W'(bus.done_o), W'(0));
            end
            rst = 1'b0;
            repeat (W + 4) begin
               @(negedge clk);
               chk({tag, ".after_rst_no_done"}, W'(bus.done_o), W'(0));
            end
            return;
         end
         chk({tag, ".busy"}, W'(bus.ready_o), W'(0));
         if (bus.done_o) begin
            seen = 1'b1;
            chk({tag, ".latency"}, W'(cyc), W'(lat));
            chk({tag, ".q"}, bus.quotient_o, eq);
            chk({tag, ".r"}, bus.remainder_o, er);
            chk({tag, ".dz"}, W'(bus.div_by_zero_o), W'(edz));
         end
         bus.start_i = (cyc == inj_cyc);
         if (cyc == inj_cyc) begin
            bus.dividend_i = ia;
            bus.divisor_i  = ib;
         end
         @(negedge clk);
         cyc++;
      end
      bus.start_i = 1'b0;
      chk({tag, ".done_seen"}, W'(seen), W'(1));
      chk({tag, ".pulse_end"}, W'(bus.done_o), W'(0));
      chk({tag, ".ready_back"}, W'(bus.ready_o), W'(1));
      chk({tag, ".q_held"}, bus.quotient_o, eq);
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      rst            = 1'b1;
      bus.start_i    = 1'b0;
      bus.dividend_i = '0;
      bus.divisor_i  = '0;
`ifdef DIVIDE_SIGNED_EN
      bus.signed_i   = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("reset.ready", W'(bus.ready_o), W'(1));
      chk("reset.done", W'(bus.done_o), W'(0));
      chk("reset.q", bus.quotient_o, '0);
      chk("reset.r", bus.remainder_o, '0);
      chk("reset.dz", W'(bus.div_by_zero_o), W'(0));
      rst = 1'b0;

      run_op(32'd100, 32'd7, 1'b0, -1, '0, '0, -1, "d100_7");
      run_op(32'd5, 32'd0, 1'b0, -1, '0, '0, -1, "d5_0");
      run_op(32'hFFFFFFFF, 32'd1, 1'b0, -1, '0, '0, -1, "dmax_1");
      run_op(32'd3, 32'd10, 1'b0, -1, '0, '0, -1, "d3_10");
      run_op(32'd100, 32'd7, 1'b0, 10, 32'd9, 32'd3, -1, "ignore_start");
      run_op(32'd9, 32'd3, 1'b0, -1, '0, '0, -1, "d9_3");
      run_op(32'd100, 32'd7, 1'b0, -1, '0, '0, 15, "abort");
      run_op(32'd20, 32'd6, 1'b0, -1, '0, '0, -1, "d20_6");

      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = W'($urandom_range(1, 15));
            1:       b = $urandom;
            2:       b = $urandom >> $urandom_range(0, 31);
            default: b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 1000));
         endcase
         run_op(a, b, 1'b0, -1, '0, '0, -1, "rand_u");
      end

`ifdef DIVIDE_SIGNED_EN
      run_op(-32'sd7, 32'sd2, 1'b1, -1, '0, '0, -1, "s_m7_2");
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, -1, '0, '0, -1, "s_min_m1");
      run_op(-32'sd5, 32'd0, 1'b1, -1, '0, '0, -1, "s_m5_0");
      run_op(32'hFFFFFFF9, 32'd2, 1'b0, -1, '0, '0, -1, "u_big_2");
      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 1) == 0) ? W'($signed(-$urandom_range(1, 50))) : $urandom;
         run_op(a, b, 1'b1, -1, '0, '0, -1, "rand_s");
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
